// File: rtl/mmio_csr_responder.sv
// CCI-P MMIO responder: decodes MMIO headers, holds a 64-bit CSR file and returns
// tid-tagged read data through a fixed-latency pipeline into a ready/valid response FIFO.
module mmio_csr_responder #(
  parameter int          NUM_CSR         = 16,
  parameter logic [15:0] CSR_BASE_INDEX  = 16'h0,
  parameter logic [63:0] ID_VALUE        = 64'h0,
  parameter int          RD_LATENCY      = 2,
  parameter int          RSP_DEPTH_BASE2 = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mmio_wr_valid,
  input  logic                   mmio_rd_valid,
  input  logic [27:0]            mmio_hdr,
  input  logic [63:0]            mmio_wrdata,
  input  logic                   rsp_ready,
  output logic                   rsp_valid,
  output logic [8:0]             rsp_tid,
  output logic [63:0]            rsp_data,
  output logic                   rd_full,
  output logic [NUM_CSR*64-1:0]  csr_q,
  output logic [NUM_CSR-1:0]     csr_wr_pulse,
  output logic [15:0]            err_cnt
);

  localparam int DEPTH = 2 ** RSP_DEPTH_BASE2;
  localparam int IW    = (NUM_CSR > 1) ? $clog2(NUM_CSR) : 1;
  localparam int AW    = RSP_DEPTH_BASE2;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [15:0]    w_index;
  logic [1:0]     w_len;
  logic [8:0]     w_tid;
  logic           w_unused;
  logic [16:0]    w_off;
  logic           w_mapped;
  logic           w_lenOk;
  logic           w_decErr;
  logic [IW-1:0]  w_regIdx;
  logic [63:0]    w_rdCsr;
  logic [63:0]    w_rdData;
  logic           w_rdAccept;
  logic           w_pop;
  logic           w_errInc;
  logic           w_fifoWr;
  logic [72:0]    w_fifoEntry;

  logic [63:0]         r_csr [NUM_CSR];
  logic [NUM_CSR-1:0]  r_pulse;
  logic [15:0]         r_errCnt;
  logic [AW:0]         r_outstanding;
  logic [72:0]         r_mem [DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [AW:0]         r_count;

  assign {w_index, w_len} = mmio_hdr[27:10];
  assign w_unused         = mmio_hdr[9];
  assign w_tid            = mmio_hdr[8:0];

  // 17-bit subtraction so an index below the base shows up as a set borrow bit.
  assign w_off    = {1'b0, w_index} - {1'b0, CSR_BASE_INDEX};
  assign w_mapped = !w_off[16] && (int'(w_off[15:1]) < NUM_CSR);
  assign w_lenOk  = (w_len == 2'b00) || ((w_len == 2'b01) && !w_off[0]);
  assign w_decErr = !w_mapped || !w_lenOk;
  assign w_regIdx = w_off[IW:1];
  assign w_rdCsr  = r_csr[w_regIdx];

  always_comb begin
    w_rdData = '0;
    if (!w_decErr) begin
      if (w_len[0]) w_rdData = w_rdCsr;
      else          w_rdData[31:0] = w_off[0] ? w_rdCsr[63:32] : w_rdCsr[31:0];
    end
  end

  assign rd_full    = (r_outstanding == FULL_CNT);
  assign w_rdAccept = mmio_rd_valid && !mmio_wr_valid && !rd_full;
  assign w_pop      = rsp_valid && rsp_ready;
  assign w_errInc   = (mmio_wr_valid && w_decErr) ||
                      (mmio_rd_valid && (mmio_wr_valid || rd_full || w_decErr));

  generate
    if (RD_LATENCY == 1) begin : g_noPipe
      assign w_fifoWr    = w_rdAccept;
      assign w_fifoEntry = {w_tid, w_rdData};
    end else begin : g_pipe
      logic [RD_LATENCY-2:0] r_pv;
      logic [72:0]           r_pd [RD_LATENCY-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pv <= '0;
          for (int k = 0; k < RD_LATENCY - 1; k++) r_pd[k] <= '0;
        end else begin
          r_pv[0] <= w_rdAccept;
          r_pd[0] <= {w_tid, w_rdData};
          for (int k = 1; k < RD_LATENCY - 1; k++) begin
            r_pv[k] <= r_pv[k-1];
            r_pd[k] <= r_pd[k-1];
          end
        end
      end

      assign w_fifoWr    = r_pv[RD_LATENCY-2];
      assign w_fifoEntry = r_pd[RD_LATENCY-2];
    end
  endgenerate

  // Outstanding spans pipeline and FIFO, so the FIFO can never overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
      r_errCnt      <= '0;
    end else begin
      case ({w_rdAccept, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_errInc && (r_errCnt != 16'hFFFF)) r_errCnt <= r_errCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      if (w_fifoWr) begin
        r_mem[r_wptr] <= w_fifoEntry;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_fifoWr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // CSR0 holds the ID constant and is never written; CSR0 writes are not errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csr[0] <= ID_VALUE;
      for (int k = 1; k < NUM_CSR; k++) r_csr[k] <= '0;
      r_pulse <= '0;
    end else begin
      r_pulse <= '0;
      if (mmio_wr_valid && !w_decErr && (w_regIdx != '0)) begin
        r_pulse[w_regIdx] <= 1'b1;
        if (w_len[0])     r_csr[w_regIdx]        <= mmio_wrdata;
        else if (w_off[0]) r_csr[w_regIdx][63:32] <= mmio_wrdata[31:0];
        else              r_csr[w_regIdx][31:0]  <= mmio_wrdata[31:0];
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_CSR; i++) begin : g_csrQ
      assign csr_q[64*i +: 64] = r_csr[i];
    end
  endgenerate

  assign rsp_valid    = (r_count != '0);
  assign rsp_tid      = r_mem[r_rptr][72:64];
  assign rsp_data     = r_mem[r_rptr][63:0];
  assign csr_wr_pulse = r_pulse;
  assign err_cnt      = r_errCnt;

endmodule

// File: tb/tb_mmio_csr_responder.sv
// Directed bench for mmio_csr_responder: drives on the falling edge, checks
// hand-computed values on the falling edge with immediate assertions.
module tb_mmio_csr_responder;

  localparam logic [63:0] ID = 64'hA5A5_0000_1234_5678;

  logic              clk;
  logic              rst_n;
  logic              mmioWrValid;
  logic              mmioRdValid;
  logic [27:0]       mmioHdr;
  logic [63:0]       mmioWrData;
  logic              rspReady;
  logic              rspValid;
  logic [8:0]        rspTid;
  logic [63:0]       rspData;
  logic              rdFull;
  logic [16*64-1:0]  csrQ;
  logic [15:0]       csrWrPulse;
  logic [15:0]       errCnt;

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;

  mmio_csr_responder #(
    .NUM_CSR(16), .CSR_BASE_INDEX(16'h0), .ID_VALUE(ID),
    .RD_LATENCY(2), .RSP_DEPTH_BASE2(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mmio_wr_valid(mmioWrValid), .mmio_rd_valid(mmioRdValid),
    .mmio_hdr(mmioHdr), .mmio_wrdata(mmioWrData), .rsp_ready(rspReady),
    .rsp_valid(rspValid), .rsp_tid(rspTid), .rsp_data(rspData),
    .rd_full(rdFull), .csr_q(csrQ), .csr_wr_pulse(csrWrPulse), .err_cnt(errCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [27:0] makeHdr(input logic [15:0] idx, input logic [1:0] len,
                                          input logic [8:0] tid);
    return {idx, len, 1'b0, tid};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [27:0] hdr,
                               input logic [63:0] wdata);
    mmioWrValid = wr;
    mmioRdValid = rd;
    mmioHdr     = hdr;
    mmioWrData  = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    rspReady = 1'b1;
    applyStimulus(1'b0, 1'b0, '0, '0);
    #12;
    @(negedge clk);
    checkOutput("reset rsp_valid", 64'(rspValid), 64'd0);
    checkOutput("reset rd_full", 64'(rdFull), 64'd0);
    checkOutput("reset err_cnt", 64'(errCnt), 64'd0);
    checkOutput("reset pulse", 64'(csrWrPulse), 64'd0);
    checkOutput("reset csr0", csrQ[63:0], ID);
    checkOutput("reset csr1", csrQ[127:64], 64'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] test 1: ID register read");
    applyStimulus(1'b0, 1'b1, makeHdr(16'd0, 2'b01, 9'h1A5), '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("t1 no early valid", 64'(rspValid), 64'd0);
    tick();
    checkOutput("t1 valid", 64'(rspValid), 64'd1);
    checkOutput("t1 tid", 64'(rspTid), 64'h1A5);
    checkOutput("t1 data", rspData, ID);
    tick();
    checkOutput("t1 single rsp", 64'(rspValid), 64'd0);

    $display("[TB] test 2: 64-bit then upper 32-bit write");
    applyStimulus(1'b1, 1'b0, makeHdr(16'd2, 2'b01, 9'h0), 64'hDEAD_BEEF_0123_4567);
    tick();
    checkOutput("t2 pulse a", 64'(csrWrPulse), 64'h0002);
    checkOutput("t2 csr1 a", csrQ[127:64], 64'hDEAD_BEEF_0123_4567);
    applyStimulus(1'b1, 1'b0, makeHdr(16'd3, 2'b00, 9'h0), 64'h0000_0000_CAFE_F00D);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("t2 pulse b", 64'(csrWrPulse), 64'h0002);
    checkOutput("t2 csr1 b", csrQ[127:64], 64'hCAFE_F00D_0123_4567);
    tick();
    checkOutput("t2 pulse off", 64'(csrWrPulse), 64'd0);

    $display("[TB] test 3: flow control with rsp_ready low");
    rspReady = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) checkOutput("t3 not full at 3", 64'(rdFull), 64'd0);
      applyStimulus(1'b0, 1'b1, makeHdr(16'd4, 2'b01, 9'(k)), '0);
      tick();
    end
    checkOutput("t3 full", 64'(rdFull), 64'd1);
    applyStimulus(1'b0, 1'b1, makeHdr(16'd4, 2'b01, 9'd5), '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("t3 err drop", 64'(errCnt), 64'd1);
    checkOutput("t3 head valid", 64'(rspValid), 64'd1);
    checkOutput("t3 head tid", 64'(rspTid), 64'd1);
    tick();
    checkOutput("t3 stable tid", 64'(rspTid), 64'd1);
    rspReady = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checkOutput($sformatf("t3 order %0d", k), 64'(rspTid), 64'(k));
      checkOutput($sformatf("t3 valid %0d", k), 64'(rspValid), 64'd1);
      tick();
    end
    checkOutput("t3 drained", 64'(rspValid), 64'd0);
    checkOutput("t3 full clear", 64'(rdFull), 64'd0);

    $display("[TB] test 4: errored reads");
    applyStimulus(1'b0, 1'b1, makeHdr(16'd3, 2'b01, 9'h011), '0);
    tick();
    applyStimulus(1'b0, 1'b1, makeHdr(16'd40, 2'b01, 9'h012), '0);
    tick();
    applyStimulus(1'b0, 1'b1, makeHdr(16'd6, 2'b11, 9'h013), '0);
    checkOutput("t4 tid a", 64'(rspTid), 64'h011);
    checkOutput("t4 data a", rspData, 64'd0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("t4 tid b", 64'(rspTid), 64'h012);
    checkOutput("t4 data b", rspData, 64'd0);
    tick();
    checkOutput("t4 tid c", 64'(rspTid), 64'h013);
    checkOutput("t4 data c", rspData, 64'd0);
    tick();
    checkOutput("t4 drained", 64'(rspValid), 64'd0);
    checkOutput("t4 err_cnt", 64'(errCnt), 64'd4);
    checkOutput("t4 csr1 kept", csrQ[127:64], 64'hCAFE_F00D_0123_4567);

    $display("[TB] test 5: simultaneous wr/rd, then reset mid-flight");
    applyStimulus(1'b1, 1'b1, makeHdr(16'd2, 2'b01, 9'h021), 64'h1111_2222_3333_4444);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("t5 csr1 written", csrQ[127:64], 64'h1111_2222_3333_4444);
    checkOutput("t5 err_cnt", 64'(errCnt), 64'd5);
    tick();
    checkOutput("t5 no rsp a", 64'(rspValid), 64'd0);
    tick();
    checkOutput("t5 no rsp b", 64'(rspValid), 64'd0);
    rspReady = 1'b0;
    applyStimulus(1'b0, 1'b1, makeHdr(16'd2, 2'b01, 9'h031), '0);
    tick();
    applyStimulus(1'b0, 1'b1, makeHdr(16'd2, 2'b01, 9'h032), '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("t5 inflight valid", 64'(rspValid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t5 async valid", 64'(rspValid), 64'd0);
    checkOutput("t5 async err", 64'(errCnt), 64'd0);
    checkOutput("t5 async csr1", csrQ[127:64], 64'd0);
    checkOutput("t5 async full", 64'(rdFull), 64'd0);
    checkOutput("t5 async tid", 64'(rspTid), 64'd0);
    tick();
    rst_n = 1'b1;
    rspReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput($sformatf("t5 no rsp after reset %0d", k), 64'(rspValid), 64'd0);
    end

    $display("[TB] test 6: write then 32-bit reads, CSR0 write ignored");
    applyStimulus(1'b1, 1'b0, makeHdr(16'd4, 2'b01, 9'h0), 64'h0BAD_CAFE_1357_9BDF);
    tick();
    applyStimulus(1'b0, 1'b1, makeHdr(16'd5, 2'b00, 9'h066), '0);
    tick();
    applyStimulus(1'b0, 1'b1, makeHdr(16'd4, 2'b00, 9'h067), '0);
    tick();
    applyStimulus(1'b1, 1'b0, makeHdr(16'd0, 2'b01, 9'h0), 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("t6 tid upper", 64'(rspTid), 64'h066);
    checkOutput("t6 data upper", rspData, 64'h0000_0000_0BAD_CAFE);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("t6 tid lower", 64'(rspTid), 64'h067);
    checkOutput("t6 data lower", rspData, 64'h0000_0000_1357_9BDF);
    checkOutput("t6 csr0 kept", csrQ[63:0], ID);
    checkOutput("t6 csr0 no pulse", 64'(csrWrPulse), 64'd0);
    checkOutput("t6 csr0 no err", 64'(errCnt), 64'd0);
    tick();
    checkOutput("t6 drained", 64'(rspValid), 64'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
